buzzer_sched: RTL and testbench
===============================

BUZZER_SCHED -- requirements
Module: buzzer_sched

Interface
REQ-001 Parameter TONE_DIV, default 2000, clk cycles per buzzer tone half-period (4 kHz from 16 MHz).
REQ-002 Parameter RING_MAX, default 60, seconds an alarm rings before auto-mute.
REQ-003 Parameter SNOOZE_SEC, default 300, seconds of one snooze interval.
REQ-004 Parameter SNOOZE_MAX, default 3, snoozes allowed per alarm event.
REQ-005 Parameter TIMER_SEC, default 10, seconds a countdown-timer expiry rings.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 tick_1hz  input  1  one-cycle pulse once per second, clk-synchronous.
REQ-009 alarm_req  input  1  level; alarm time matched and alarm enabled.
REQ-010 timer_req  input  1  one-cycle pulse; countdown timer expired.
REQ-011 chime_req  input  1  one-cycle pulse; top of hour.
REQ-012 off  input  1  one-cycle pulse; debounced off button.
REQ-013 snooze  input  1  one-cycle pulse; debounced snooze button.
REQ-014 buzzer  output  1  registered tone output to the buzzer driver.
REQ-015 active_src  output  2  00 none, 01 alarm, 10 timer, 11 chime.
REQ-016 snoozing  output  1  high while in SNOOZE.

Function
REQ-017 FSM states SHALL be IDLE, ALARM, SNOOZE, MUTED, TIMER, CHIME.
REQ-018 IDLE: rising edge of alarm_req -> ALARM; else timer_req or timer_pend -> TIMER; else chime_req -> CHIME.
REQ-019 ALARM: off -> MUTED; snooze with snz_cnt < SNOOZE_MAX -> SNOOZE, snz_cnt+1; snooze at snz_cnt = SNOOZE_MAX is ignored; RING_MAX ticks elapsed -> MUTED.
REQ-020 SNOOZE: off -> IDLE; SNOOZE_SEC ticks elapsed -> ALARM, independent of alarm_req.
REQ-021 MUTED: leaves to IDLE only when alarm_req is low; entry from ALARM clears snz_cnt.
REQ-022 TIMER: off or TIMER_SEC ticks elapsed -> IDLE; rising alarm_req preempts -> ALARM, timer sets timer_pend.
REQ-023 CHIME: exactly one tick_1hz period then IDLE; off -> IDLE; rising alarm_req or timer_req preempts, chime discarded.
REQ-024 Priority alarm > timer > chime; timer_req arriving in ALARM/SNOOZE/MUTED sets timer_pend, served in IDLE; chime_req not in IDLE is dropped.
REQ-025 Simultaneous off and snooze: off wins; simultaneous alarm and timer request: ALARM, timer_pend set.
REQ-026 Seconds counter clears on every state entry; counts tick_1hz only; width SHALL hold max(RING_MAX, SNOOZE_SEC, TIMER_SEC) without wrap.
REQ-027 Tone divider SHALL reset to phase 0 with tone bit 1 on entry to any ringing state (ALARM, TIMER, CHIME) and toggle every TONE_DIV cycles.
REQ-028 buzzer = tone bit AND ringing state, registered; first high cycle is the cycle after the state-entry edge.
REQ-029 buzzer SHALL be 0 in IDLE, SNOOZE, MUTED within one cycle of entry.
REQ-030 active_src: ALARM/SNOOZE/MUTED -> 01, TIMER -> 10, CHIME -> 11, IDLE -> 00.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, buzzer 0, active_src 00, snoozing 0, snz_cnt 0, timer_pend 0, all counters 0.
REQ-032 Reset mid-ring SHALL silence buzzer without waiting for clk; after release, alarm_req already high does not ring (no rising edge).

Structure
REQ-033 Package buzzer_pkg SHALL hold the state enumeration and active_src codes.
REQ-034 Sub-module tone_gen (TONE_DIV, restart, enable -> tone) SHALL implement the divider.

Verification (TONE_DIV=4, RING_MAX=5, SNOOZE_SEC=3, SNOOZE_MAX=2, TIMER_SEC=4)
REQ-035 alarm_req rise, no buttons -> buzzer toggles every 4 clk, active_src 01; after 5 ticks MUTED, buzzer 0; alarm_req low -> IDLE.
REQ-036 Alarm, snooze x3 each after re-ring -> snoozing high 3 ticks twice, third snooze ignored, buzzer continues.
REQ-037 timer_req during ALARM, then off -> MUTED; alarm_req low -> IDLE then TIMER, rings 4 ticks, active_src 10.
REQ-038 chime_req in IDLE -> buzzer 1 tick; chime_req during TIMER -> dropped, no CHIME afterward.
REQ-039 off and snooze same cycle in ALARM -> MUTED, snoozing stays 0, snz_cnt 0.
REQ-040 rst_n low mid-TIMER between clk edges -> buzzer 0 immediately; release with alarm_req high -> stays IDLE.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer scheduler: FSM state encoding and active_src codes.
package buzzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALARM  = 3'd1,
    ST_SNOOZE = 3'd2,
    ST_MUTED  = 3'd3,
    ST_TIMER  = 3'd4,
    ST_CHIME  = 3'd5
  } state_e;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_ALARM = 2'b01;
  localparam logic [1:0] SRC_TIMER = 2'b10;
  localparam logic [1:0] SRC_CHIME = 2'b11;

  function automatic logic is_ringing(state_e s);
    return (s == ST_ALARM) || (s == ST_TIMER) || (s == ST_CHIME);
  endfunction

  function automatic logic [1:0] src_of(state_e s);
    logic [1:0] src;
    unique case (s)
      ST_ALARM, ST_SNOOZE, ST_MUTED: src = SRC_ALARM;
      ST_TIMER:                      src = SRC_TIMER;
      ST_CHIME:                      src = SRC_CHIME;
      default:                       src = SRC_NONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone divider: tone toggles every TONE_DIV enabled cycles;
// restart forces phase 0 with the tone bit high so every ring starts identically.
module tone_gen #(
  parameter int TONE_DIV = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic tone
);

  localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TONE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (restart) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/buzzer_sched.sv
// Buzzer scheduler: arbitrates alarm, countdown-timer and hourly chime onto one buzzer.
// Alarm outranks timer outranks chime; a displaced timer expiry is remembered in timer_pend.
module buzzer_sched
  import buzzer_pkg::*;
#(
  parameter int TONE_DIV   = 2000,
  parameter int RING_MAX   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int SNOOZE_MAX = 3,
  parameter int TIMER_SEC  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       alarm_req,
  input  logic       timer_req,
  input  logic       chime_req,
  input  logic       off,
  input  logic       snooze,
  output logic       buzzer,
  output logic [1:0] active_src,
  output logic       snoozing,
  output state_e     state_dbg
);

  localparam int SEC_MAX_A = (RING_MAX > SNOOZE_SEC) ? RING_MAX : SNOOZE_SEC;
  localparam int SEC_MAX   = (SEC_MAX_A > TIMER_SEC) ? SEC_MAX_A : TIMER_SEC;
  localparam int SW        = (SEC_MAX > 0) ? $clog2(SEC_MAX + 1) : 1;
  localparam int SW1       = SW + 1;
  localparam int NW        = (SNOOZE_MAX > 0) ? $clog2(SNOOZE_MAX + 1) : 1;

  localparam logic [SW-1:0] SEC_TOP  = SW'(SEC_MAX);
  localparam logic [SW:0]   RING_L   = SW1'(RING_MAX);
  localparam logic [SW:0]   SNZ_L    = SW1'(SNOOZE_SEC);
  localparam logic [SW:0]   TMR_L    = SW1'(TIMER_SEC);
  localparam logic [NW-1:0] SNZ_LIM  = NW'(SNOOZE_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [SW:0]   sec_inc;
  logic [NW-1:0] snz_q, snz_d;
  logic          pend_q, pend_d;
  logic          alarm_prev_q;
  logic          buzzer_q, buzzer_d;
  logic          alarm_rise, entering, tone_restart, tone;
  logic          ring_done, snz_done, tmr_done;

  assign alarm_rise = alarm_req & ~alarm_prev_q;
  assign sec_inc    = {1'b0, sec_q} + SW1'(1);
  // A timeout fires on the tick that would bring the elapsed count up to the limit.
  assign ring_done  = tick_1hz && (sec_inc == RING_L);
  assign snz_done   = tick_1hz && (sec_inc == SNZ_L);
  assign tmr_done   = tick_1hz && (sec_inc == TMR_L);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    snz_d   = snz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (alarm_rise) begin
          state_d = ST_ALARM;
          pend_d  = pend_q | timer_req;
        end else if (timer_req || pend_q) begin
          state_d = ST_TIMER;
        end else if (chime_req) begin
          state_d = ST_CHIME;
        end
      end
      ST_ALARM: begin
        pend_d = pend_q | timer_req;
        if (off) begin
          state_d = ST_MUTED;
        end else if (snooze && (snz_q < SNZ_LIM)) begin
          state_d = ST_SNOOZE;
          snz_d   = snz_q + NW'(1);
        end else if (ring_done) begin
          state_d = ST_MUTED;
        end
      end
      ST_SNOOZE: begin
        pend_d = pend_q | timer_req;
        if (off) state_d = ST_IDLE;
        else if (snz_done) state_d = ST_ALARM;
      end
      ST_MUTED: begin
        pend_d = pend_q | timer_req;
        if (!alarm_req) state_d = ST_IDLE;
      end
      ST_TIMER: begin
        if (alarm_rise) begin
          state_d = ST_ALARM;
          pend_d  = 1'b1;
        end else if (off || tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHIME: begin
        if (alarm_rise) begin
          state_d = ST_ALARM;
          pend_d  = pend_q | timer_req;
        end else if (timer_req) begin
          state_d = ST_TIMER;
        end else if (off || tick_1hz) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    entering = (state_d != state_q);
    if (entering && (state_d == ST_TIMER)) pend_d = 1'b0;
    // Snooze budget is per alarm event: a fresh ALARM (not a re-ring) or MUTED resets it.
    if (entering && (state_d == ST_MUTED)) snz_d = '0;
    if (entering && (state_d == ST_ALARM) && (state_q != ST_SNOOZE)) snz_d = '0;

    if (entering) sec_d = '0;
    else if (tick_1hz && (sec_q != SEC_TOP)) sec_d = sec_q + SW'(1);
    else sec_d = sec_q;

    tone_restart = entering && is_ringing(state_d);
    buzzer_d     = tone & is_ringing(state_q);
  end

  tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (tone_restart),
    .enable  (is_ringing(state_q)),
    .tone    (tone)
  );

  // alarm_prev resets high so a level already present at reset release is not a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sec_q        <= '0;
      snz_q        <= '0;
      pend_q       <= 1'b0;
      alarm_prev_q <= 1'b1;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      snz_q        <= snz_d;
      pend_q       <= pend_d;
      alarm_prev_q <= alarm_req;
      buzzer_q     <= buzzer_d;
    end
  end

  assign buzzer     = buzzer_q;
  assign active_src = src_of(state_q);
  assign snoozing   = (state_q == ST_SNOOZE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// behavioural model of the scheduling rules (mode, elapsed seconds, cycles since entry).
module tb_buzzer_sched;
  import buzzer_pkg::*;

  localparam int TONE_DIV   = 4;
  localparam int RING_MAX   = 5;
  localparam int SNOOZE_SEC = 3;
  localparam int SNOOZE_MAX = 2;
  localparam int TIMER_SEC  = 4;

  localparam int M_IDLE = 0, M_ALARM = 1, M_SNOOZE = 2, M_MUTED = 3, M_TIMER = 4, M_CHIME = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1hz = 1'b0, alarm_req = 1'b0, timer_req = 1'b0;
  logic chime_req = 1'b0, off = 1'b0, snooze = 1'b0;
  logic       buzzer;
  logic [1:0] active_src;
  logic       snoozing;
  state_e     state_dbg;

  int checks = 0;
  int errors = 0;

  int m_mode, m_pend, m_snz, m_secs, m_cyc;
  bit m_prev_alarm, exp_buzz;
  int tick_per = 6;
  int tick_ctr = 0;
  bit rand_tick = 1'b0;

  buzzer_sched #(
    .TONE_DIV   (TONE_DIV),
    .RING_MAX   (RING_MAX),
    .SNOOZE_SEC (SNOOZE_SEC),
    .SNOOZE_MAX (SNOOZE_MAX),
    .TIMER_SEC  (TIMER_SEC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .alarm_req  (alarm_req),
    .timer_req  (timer_req),
    .chime_req  (chime_req),
    .off        (off),
    .snooze     (snooze),
    .buzzer     (buzzer),
    .active_src (active_src),
    .snoozing   (snoozing),
    .state_dbg  (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit ringing(int m);
    return (m == M_ALARM) || (m == M_TIMER) || (m == M_CHIME);
  endfunction

  function automatic logic [1:0] exp_src(int m);
    if (m == M_ALARM || m == M_SNOOZE || m == M_MUTED) return 2'b01;
    if (m == M_TIMER) return 2'b10;
    if (m == M_CHIME) return 2'b11;
    return 2'b00;
  endfunction

  function automatic state_e exp_state(int m);
    case (m)
      M_ALARM:  return ST_ALARM;
      M_SNOOZE: return ST_SNOOZE;
      M_MUTED:  return ST_MUTED;
      M_TIMER:  return ST_TIMER;
      M_CHIME:  return ST_CHIME;
      default:  return ST_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pend = 0; m_snz = 0; m_secs = 0; m_cyc = 0;
    m_prev_alarm = 1'b1; exp_buzz = 1'b0;
  endtask

  // One clock of the reference behaviour, using the inputs sampled at this edge.
  task automatic model_step();
    int nm;
    int secs_after;
    bit rise;
    rise = alarm_req && !m_prev_alarm;
    secs_after = m_secs + (tick_1hz ? 1 : 0);
    exp_buzz = ringing(m_mode) && (((m_cyc / TONE_DIV) % 2) == 0);
    nm = m_mode;
    case (m_mode)
      M_IDLE: begin
        if (rise) begin nm = M_ALARM; m_snz = 0; if (timer_req) m_pend = 1; end
        else if (timer_req || m_pend != 0) begin nm = M_TIMER; m_pend = 0; end
        else if (chime_req) nm = M_CHIME;
      end
      M_ALARM: begin
        if (timer_req) m_pend = 1;
        if (off) begin nm = M_MUTED; m_snz = 0; end
        else if (snooze && m_snz < SNOOZE_MAX) begin nm = M_SNOOZE; m_snz++; end
        else if (tick_1hz && secs_after == RING_MAX) begin nm = M_MUTED; m_snz = 0; end
      end
      M_SNOOZE: begin
        if (timer_req) m_pend = 1;
        if (off) nm = M_IDLE;
        else if (tick_1hz && secs_after == SNOOZE_SEC) nm = M_ALARM;
      end
      M_MUTED: begin
        if (timer_req) m_pend = 1;
        if (!alarm_req) nm = M_IDLE;
      end
      M_TIMER: begin
        if (rise) begin nm = M_ALARM; m_snz = 0; m_pend = 1; end
        else if (off || (tick_1hz && secs_after == TIMER_SEC)) nm = M_IDLE;
      end
      M_CHIME: begin
        if (rise) begin nm = M_ALARM; m_snz = 0; if (timer_req) m_pend = 1; end
        else if (timer_req) begin nm = M_TIMER; m_pend = 0; end
        else if (off || tick_1hz) nm = M_IDLE;
      end
      default: nm = M_IDLE;
    endcase
    if (nm != m_mode) begin m_secs = 0; m_cyc = 0; end
    else begin m_secs = secs_after; m_cyc++; end
    m_mode = nm;
    m_prev_alarm = alarm_req;
  endtask

  task automatic check_outputs();
    chk("buzzer", buzzer, exp_buzz);
    chk("active_src", active_src, exp_src(m_mode));
    chk("snoozing", snoozing, (m_mode == M_SNOOZE));
    chk("state", state_dbg, exp_state(m_mode));
  endtask

  // driver: apply inputs for one cycle, step the model at the edge, check at the falling edge
  task automatic cyc();
    if (rand_tick) tick_1hz = ($urandom_range(0, 4) == 0);
    else begin
      tick_1hz = (tick_ctr == tick_per - 1);
      tick_ctr = (tick_ctr + 1) % tick_per;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    timer_req = 1'b0; chime_req = 1'b0; off = 1'b0; snooze = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  initial begin
    // reset
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_buzzer", buzzer, 1'b0);
    chk("rst_src", active_src, 2'b00);
    chk("rst_snoozing", snoozing, 1'b0);
    chk("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    run(2);

    // plain alarm: rings, auto-mutes after RING_MAX ticks, idles once alarm_req drops
    alarm_req = 1'b1; cyc();
    chk("alarm_src", active_src, 2'b01);
    chk("alarm_entry_buzz_low", buzzer, 1'b0);
    cyc();
    chk("alarm_first_high", buzzer, 1'b1);
    run(40);
    chk("auto_mute_state", state_dbg, ST_MUTED);
    chk("auto_mute_buzz", buzzer, 1'b0);
    alarm_req = 1'b0; run(2);
    chk("mute_release", state_dbg, ST_IDLE);

    // snooze twice, third snooze ignored
    alarm_req = 1'b1; cyc(); run(2);
    snooze = 1'b1; cyc();
    chk("snooze1", snoozing, 1'b1);
    run(20);
    chk("rering1", state_dbg, ST_ALARM);
    snooze = 1'b1; cyc();
    chk("snooze2", snoozing, 1'b1);
    run(20);
    chk("rering2", state_dbg, ST_ALARM);
    snooze = 1'b1; cyc();
    chk("snooze3_ignored", snoozing, 1'b0);
    run(4);
    off = 1'b1; cyc();
    chk("off_mutes", state_dbg, ST_MUTED);
    alarm_req = 1'b0; run(2);

    // timer expiry during alarm is deferred until the alarm is finished
    alarm_req = 1'b1; cyc(); run(3);
    timer_req = 1'b1; cyc(); run(2);
    off = 1'b1; cyc();
    chk("pend_muted", state_dbg, ST_MUTED);
    run(3);
    alarm_req = 1'b0; cyc();
    chk("pend_idle", state_dbg, ST_IDLE);
    cyc();
    chk("pend_timer_src", active_src, 2'b10);
    run(30);
    chk("timer_done", state_dbg, ST_IDLE);

    // chime in idle, chime dropped while the timer rings
    chime_req = 1'b1; cyc();
    chk("chime_src", active_src, 2'b11);
    run(8);
    chk("chime_done", state_dbg, ST_IDLE);
    timer_req = 1'b1; cyc(); run(2);
    chime_req = 1'b1; cyc();
    chk("chime_dropped", active_src, 2'b10);
    run(30);
    chk("no_late_chime", state_dbg, ST_IDLE);

    // off and snooze together: off wins, snooze budget cleared
    alarm_req = 1'b1; cyc(); run(2);
    off = 1'b1; snooze = 1'b1; cyc();
    chk("off_wins_state", state_dbg, ST_MUTED);
    chk("off_wins_snoozing", snoozing, 1'b0);
    alarm_req = 1'b0; run(2);
    alarm_req = 1'b1; cyc();
    snooze = 1'b1; cyc();
    chk("snz_budget_fresh", snoozing, 1'b1);
    off = 1'b1; cyc();
    chk("snooze_off_idle", state_dbg, ST_IDLE);
    alarm_req = 1'b0; run(2);

    // asynchronous reset in the middle of a timer ring
    timer_req = 1'b1; cyc(); run(2);
    chk("pre_reset_buzz", buzzer, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_buzz", buzzer, 1'b0);
    chk("async_rst_src", active_src, 2'b00);
    model_reset();
    alarm_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run(5);
    chk("no_ring_after_rst", state_dbg, ST_IDLE);
    chk("no_buzz_after_rst", buzzer, 1'b0);

    // random traffic
    rand_tick = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) alarm_req = ~alarm_req;
      timer_req = ($urandom_range(0, 29) == 0);
      chime_req = ($urandom_range(0, 29) == 0);
      off       = ($urandom_range(0, 24) == 0);
      snooze    = ($urandom_range(0, 14) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
